// File: rtl/sram_wb_bridge.sv
// SRAM-style CPU data port to Wishbone B3 classic single-cycle master.
// Stalls the core until ack, error or timeout; errors give a one-cycle pulse.
module sram_wb_bridge #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sram_ce_i,
  input  logic        sram_we_i,
  input  logic [31:0] sram_addr_i,
  input  logic [3:0]  sram_sel_i,
  input  logic [31:0] sram_data_i,
  output logic [31:0] sram_data_o,
  output logic        stall_o,
  output logic        bus_err_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [9:0] TO = 10'(TIMEOUT);

  state_t      state_q, state_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] rdata_q, rdata_d;
  logic [9:0]  cnt_q, cnt_d;
  logic        err_q, err_d;

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    adr_d   = adr_q;
    sel_d   = sel_q;
    dat_d   = dat_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (sram_ce_i) begin
          we_d    = sram_we_i;
          adr_d   = {sram_addr_i[31:2], 2'b00};
          sel_d   = sram_sel_i;
          dat_d   = sram_data_i;
          cyc_d   = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 10'd1;
        // Error beats a simultaneous ack
        if (wb_err_i || cnt_d == TO) begin
          rdata_d = '0;
          err_d   = 1'b1;
          cyc_d   = 1'b0;
          state_d = DONE;
        end else if (wb_ack_i) begin
          if (!we_q) rdata_d = wb_dat_i;
          cyc_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      sel_q   <= '0;
      dat_q   <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign stall_o     = (state_q == IDLE && sram_ce_i) || state_q == BUSY;
  assign bus_err_o   = err_q;
  assign sram_data_o = rdata_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;
  assign wb_we_o     = we_q;
  assign wb_adr_o    = adr_q;
  assign wb_sel_o    = sel_q;
  assign wb_dat_o    = dat_q;

endmodule

// File: tb/tb_sram_wb_bridge.sv
// Directed bench for sram_wb_bridge with TIMEOUT=8.
// Inputs change 2 time units after each rising edge; checks follow 1 unit later.
module tb_sram_wb_bridge;

  logic        clk;
  logic        rst;
  logic        sram_ce_i;
  logic        sram_we_i;
  logic [31:0] sram_addr_i;
  logic [3:0]  sram_sel_i;
  logic [31:0] sram_data_i;
  logic [31:0] sram_data_o;
  logic        stall_o;
  logic        bus_err_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  int errors = 0;
  int checks = 0;

  sram_wb_bridge #(.TIMEOUT(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .sram_ce_i   (sram_ce_i),
    .sram_we_i   (sram_we_i),
    .sram_addr_i (sram_addr_i),
    .sram_sel_i  (sram_sel_i),
    .sram_data_i (sram_data_i),
    .sram_data_o (sram_data_o),
    .stall_o     (stall_o),
    .bus_err_o   (bus_err_o),
    .wb_cyc_o    (wb_cyc_o),
    .wb_stb_o    (wb_stb_o),
    .wb_we_o     (wb_we_o),
    .wb_adr_o    (wb_adr_o),
    .wb_sel_o    (wb_sel_o),
    .wb_dat_o    (wb_dat_o),
    .wb_dat_i    (wb_dat_i),
    .wb_ack_i    (wb_ack_i),
    .wb_err_i    (wb_err_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic req(input logic we, input logic [31:0] a,
                     input logic [3:0] s, input logic [31:0] d);
    sram_ce_i   = 1'b1;
    sram_we_i   = we;
    sram_addr_i = a;
    sram_sel_i  = s;
    sram_data_i = d;
  endtask

  initial begin
    rst         = 1'b1;
    sram_ce_i   = 1'b0;
    sram_we_i   = 1'b0;
    sram_addr_i = '0;
    sram_sel_i  = '0;
    sram_data_i = '0;
    wb_dat_i    = '0;
    wb_ack_i    = 1'b0;
    wb_err_i    = 1'b0;
    #1;
    chk("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("rst_stb", {31'd0, wb_stb_o}, 32'd0);
    chk("rst_we", {31'd0, wb_we_o}, 32'd0);
    chk("rst_adr", wb_adr_o, 32'd0);
    chk("rst_sel", {28'd0, wb_sel_o}, 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    chk("rst_rdata", sram_data_o, 32'd0);
    chk("rst_err", {31'd0, bus_err_o}, 32'd0);
    chk("rst_stall0", {31'd0, stall_o}, 32'd0);
    sram_ce_i = 1'b1;
    #1;
    chk("rst_stall1", {31'd0, stall_o}, 32'd1);
    sram_ce_i = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // read, zero-wait
    req(1'b0, 32'h0000_1006, 4'b1100, 32'h0);
    #1;
    chk("rd0_stall", {31'd0, stall_o}, 32'd1);
    chk("rd0_cyc", {31'd0, wb_cyc_o}, 32'd0);
    tick();
    wb_ack_i = 1'b1;
    wb_dat_i = 32'hA5A5_1234;
    #1;
    chk("rd1_cyc", {31'd0, wb_cyc_o}, 32'd1);
    chk("rd1_stb", {31'd0, wb_stb_o}, 32'd1);
    chk("rd1_adr", wb_adr_o, 32'h0000_1004);
    chk("rd1_sel", {28'd0, wb_sel_o}, 32'hC);
    chk("rd1_we", {31'd0, wb_we_o}, 32'd0);
    chk("rd1_stall", {31'd0, stall_o}, 32'd1);
    tick();
    wb_ack_i = 1'b0;
    wb_dat_i = 32'h0;
    #1;
    chk("rd2_data", sram_data_o, 32'hA5A5_1234);
    chk("rd2_stall", {31'd0, stall_o}, 32'd0);
    chk("rd2_err", {31'd0, bus_err_o}, 32'd0);
    chk("rd2_cyc", {31'd0, wb_cyc_o}, 32'd0);
    sram_ce_i = 1'b0;
    tick();

    // write, 3 wait states, ack in cycle 4
    req(1'b1, 32'h1000_0000, 4'hF, 32'hDEAD_BEEF);
    tick();
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) wb_ack_i = 1'b1;
      #1;
      chk("wr_cyc", {31'd0, wb_cyc_o}, 32'd1);
      chk("wr_we", {31'd0, wb_we_o}, 32'd1);
      chk("wr_dat", wb_dat_o, 32'hDEAD_BEEF);
      chk("wr_adr", wb_adr_o, 32'h1000_0000);
      chk("wr_sel", {28'd0, wb_sel_o}, 32'hF);
      chk("wr_stall", {31'd0, stall_o}, 32'd1);
      tick();
    end
    wb_ack_i = 1'b0;
    #1;
    chk("wr5_stall", {31'd0, stall_o}, 32'd0);
    chk("wr5_cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("wr5_data", sram_data_o, 32'hA5A5_1234);
    chk("wr5_err", {31'd0, bus_err_o}, 32'd0);
    sram_ce_i = 1'b0;
    tick();

    // slave error in cycle 2
    req(1'b0, 32'h0000_2000, 4'hF, 32'h0);
    tick();
    tick();
    wb_err_i = 1'b1;
    wb_dat_i = 32'h1111_2222;
    tick();
    wb_err_i = 1'b0;
    wb_dat_i = 32'h0;
    #1;
    chk("er3_err", {31'd0, bus_err_o}, 32'd1);
    chk("er3_data", sram_data_o, 32'd0);
    chk("er3_stall", {31'd0, stall_o}, 32'd0);
    tick();
    #1;
    chk("er4_err", {31'd0, bus_err_o}, 32'd0);
    chk("er4_stall", {31'd0, stall_o}, 32'd1);
    tick();
    wb_ack_i = 1'b1;
    wb_dat_i = 32'h0BAD_F00D;
    tick();
    wb_ack_i = 1'b0;
    #1;
    chk("er_next_data", sram_data_o, 32'h0BAD_F00D);
    chk("er_next_err", {31'd0, bus_err_o}, 32'd0);
    sram_ce_i = 1'b0;
    tick();

    // ack and err together: error wins
    req(1'b0, 32'h0000_3000, 4'hF, 32'h0);
    tick();
    wb_ack_i = 1'b1;
    wb_err_i = 1'b1;
    wb_dat_i = 32'h7777_7777;
    tick();
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    #1;
    chk("ae_err", {31'd0, bus_err_o}, 32'd1);
    chk("ae_data", sram_data_o, 32'd0);
    sram_ce_i = 1'b0;
    tick();

    // timeout, slave never responds
    req(1'b0, 32'h0000_4000, 4'hF, 32'h0);
    tick();
    for (int c = 1; c <= 8; c++) begin
      #1;
      chk("to_cyc", {31'd0, wb_cyc_o}, 32'd1);
      chk("to_err_lo", {31'd0, bus_err_o}, 32'd0);
      tick();
    end
    #1;
    chk("to9_cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("to9_err", {31'd0, bus_err_o}, 32'd1);
    chk("to9_stall", {31'd0, stall_o}, 32'd0);
    sram_ce_i = 1'b0;
    tick();
    #1;
    chk("to10_err", {31'd0, bus_err_o}, 32'd0);
    tick();

    // back-to-back reads, ce held high
    req(1'b0, 32'h0000_5000, 4'hF, 32'h0);
    tick();
    wb_ack_i = 1'b1;
    wb_dat_i = 32'h1234_0001;
    tick();
    wb_ack_i = 1'b0;
    sram_addr_i = 32'h0000_5004;
    #1;
    chk("bb_d1_data", sram_data_o, 32'h1234_0001);
    chk("bb_d1_cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("bb_d1_stall", {31'd0, stall_o}, 32'd0);
    tick();
    #1;
    chk("bb_i_cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("bb_i_stall", {31'd0, stall_o}, 32'd1);
    tick();
    wb_ack_i = 1'b1;
    wb_dat_i = 32'h1234_0002;
    #1;
    chk("bb_b2_cyc", {31'd0, wb_cyc_o}, 32'd1);
    chk("bb_b2_adr", wb_adr_o, 32'h0000_5004);
    tick();
    wb_ack_i = 1'b0;
    sram_ce_i = 1'b0;
    #1;
    chk("bb_d2_data", sram_data_o, 32'h1234_0002);
    tick();

    // ce drops in cycle 1, ack in cycle 3
    req(1'b0, 32'h0000_6000, 4'hF, 32'h0);
    tick();
    sram_ce_i = 1'b0;
    #1;
    chk("cd1_cyc", {31'd0, wb_cyc_o}, 32'd1);
    tick();
    #1;
    chk("cd2_cyc", {31'd0, wb_cyc_o}, 32'd1);
    chk("cd2_stall", {31'd0, stall_o}, 32'd1);
    tick();
    wb_ack_i = 1'b1;
    wb_dat_i = 32'hCAFE_0003;
    tick();
    wb_ack_i = 1'b0;
    #1;
    chk("cd4_data", sram_data_o, 32'hCAFE_0003);
    chk("cd4_cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("cd4_stall", {31'd0, stall_o}, 32'd0);
    tick();

    // reset mid-access in BUSY cycle 2
    req(1'b1, 32'h0000_7008, 4'h3, 32'h5555_AAAA);
    tick();
    tick();
    #1;
    chk("rm_busy", {31'd0, wb_cyc_o}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rm_cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("rm_stb", {31'd0, wb_stb_o}, 32'd0);
    chk("rm_we", {31'd0, wb_we_o}, 32'd0);
    chk("rm_adr", wb_adr_o, 32'd0);
    chk("rm_sel", {28'd0, wb_sel_o}, 32'd0);
    chk("rm_dat", wb_dat_o, 32'd0);
    chk("rm_rdata", sram_data_o, 32'd0);
    chk("rm_err", {31'd0, bus_err_o}, 32'd0);
    chk("rm_stall", {31'd0, stall_o}, 32'd1);
    sram_ce_i = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    req(1'b0, 32'h0000_8000, 4'hF, 32'h0);
    tick();
    wb_ack_i = 1'b1;
    wb_dat_i = 32'h600D_600D;
    tick();
    wb_ack_i = 1'b0;
    sram_ce_i = 1'b0;
    #1;
    chk("rm_next_data", sram_data_o, 32'h600D_600D);
    chk("rm_next_stall", {31'd0, stall_o}, 32'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
